// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the byte-enable single-port RAM.
// No logic of its own: state encoding, read-mode encodings, lane-merge function.
// Backpressure: not applicable.
package sp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RDM_NO_CHANGE  = 0;
    localparam int RDM_WRITE_THRU = 1;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] m;
        m = old_w;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sp_ram_be_outpipe.sv
// Optional output register stage for read data and its valid strobe.
// Latency: 1 cycle. Backpressure: none, data is captured only when valid.
// Flushed by reset only; a word in flight at reset is lost.
module sp_ram_be_outpipe #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_dat,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_dat
);

    logic              r_vld;
    logic [DATA_W-1:0] r_dat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_dat <= i_dat;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/sp_ram_be.sv
// Single-port RAM with byte enables, selectable read-during-write and post-reset clear.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), full throughput.
// Backpressure: none; accesses while o_busy=1 are silently dropped.
module sp_ram_be
    import sp_ram_pkg::*;
#(
    parameter  int DATA_W       = 8,
    parameter  int ADDR_W       = 8,
    parameter  int DEPTH        = 256,
    parameter  int RD_MODE      = 0,
    parameter  int OUT_REG      = 0,
    parameter  int CLEAR_ON_RST = 1,
    localparam int BE_W         = be_width(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_busy
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    if (DATA_W % 8 != 0) begin : g_chk_data_w
        $error("sp_ram_be: DATA_W must be a multiple of 8");
    end
    if (DATA_W > MAX_DATA_W) begin : g_chk_data_max
        $error("sp_ram_be: DATA_W exceeds MAX_DATA_W");
    end
    if (DEPTH < 1) begin : g_chk_depth_min
        $error("sp_ram_be: DEPTH must be at least 1");
    end
    if (64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_chk_depth_max
        $error("sp_ram_be: DEPTH must not exceed 2**ADDR_W");
    end
    if (RD_MODE != RDM_NO_CHANGE && RD_MODE != RDM_WRITE_THRU) begin : g_chk_rd_mode
        $error("sp_ram_be: RD_MODE must be 0 or 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic              w_busy;
    logic              w_acc;
    logic              w_in_rng;
    logic              w_ret;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_ret_dat;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == LAST_A) begin
                    w_state_nxt = ST_READY;
                end
            end
            default: begin
                w_state_nxt = ST_READY;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    assign w_busy   = (r_state == ST_CLEAR);
    assign w_acc    = i_en && !w_busy;
    assign w_in_rng = ({1'b0, i_addr} < DEPTH_L);
    assign w_old    = w_in_rng ? r_mem[i_addr] : '0;
    assign w_merged = DATA_W'(be_merge(MAX_DATA_W'(w_old), MAX_DATA_W'(i_wdata), MAX_BE_W'(i_be)));
    assign w_ret    = w_acc && (!i_we || RD_MODE != RDM_NO_CHANGE);

    // Out-of-range writes leave memory untouched, so a write-through reports zero.
    assign w_ret_dat = !w_in_rng ? '0 : (i_we ? w_merged : w_old);

    always_ff @(posedge i_clk) begin
        if (w_busy) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_acc && i_we && w_in_rng) begin
            r_mem[i_addr] <= w_merged;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_ret;
            if (w_ret) begin
                r_rdata <= w_ret_dat;
            end
        end
    end

    if (OUT_REG != 0) begin : g_opipe
        sp_ram_be_outpipe #(
            .DATA_W (DATA_W)
        ) u_outpipe (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_vld   (r_rvalid),
            .i_dat   (r_rdata),
            .o_vld   (o_rvalid),
            .o_dat   (o_rdata)
        );
    end else begin : g_nopipe
        assign o_rdata  = r_rdata;
        assign o_rvalid = r_rvalid;
    end

    assign o_busy = w_busy;

endmodule

// File: tb/tb_sp_ram_be.sv
// Five RAM configurations share one random stimulus stream and are checked
// every cycle against an array-based reference model with a latency schedule.
module tb_sp_ram_be;

    localparam int NI   = 5;
    localparam int NCYC = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    logic [31:0] rd_a, rd_b, rd_c, rd_e;
    logic [7:0]  rd_d;
    logic        rv_a, rv_b, rv_c, rv_d, rv_e;
    logic        bz_a, bz_b, bz_c, bz_d, bz_e;
    logic [31:0] rd [NI];
    logic        rv [NI];
    logic        bz [NI];

    always_comb begin
        rd[0] = rd_a; rd[1] = rd_b; rd[2] = rd_c; rd[3] = {24'd0, rd_d}; rd[4] = rd_e;
        rv[0] = rv_a; rv[1] = rv_b; rv[2] = rv_c; rv[3] = rv_d;          rv[4] = rv_e;
        bz[0] = bz_a; bz[1] = bz_b; bz[2] = bz_c; bz[3] = bz_d;          bz[4] = bz_e;
    end

    sp_ram_be #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_we(we), .i_be(be), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rd_a), .o_rvalid(rv_a), .o_busy(bz_a));
    sp_ram_be #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_MODE(1), .OUT_REG(0), .CLEAR_ON_RST(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_we(we), .i_be(be), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rd_b), .o_rvalid(rv_b), .o_busy(bz_b));
    sp_ram_be #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_MODE(0), .OUT_REG(1), .CLEAR_ON_RST(1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_we(we), .i_be(be), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rd_c), .o_rvalid(rv_c), .o_busy(bz_c));
    sp_ram_be u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_we(we), .i_be(be[0:0]), .i_addr(addr),
        .i_wdata(wdata[7:0]), .o_rdata(rd_d), .o_rvalid(rv_d), .o_busy(bz_d));
    sp_ram_be #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(0)) u_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_we(we), .i_be(be), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rd_e), .o_rvalid(rv_e), .o_busy(bz_e));

    // Per-instance configuration as seen by the model.
    int          depth_m [NI] = '{256, 256, 200, 256, 256};
    bit          rdm_m   [NI] = '{0, 1, 0, 0, 1};
    int          lat_m   [NI] = '{1, 1, 2, 1, 2};
    int          lanes_m [NI] = '{4, 4, 4, 1, 4};
    bit          clr_m   [NI] = '{1, 1, 1, 1, 0};
    logic [31:0] mask_m  [NI] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};

    logic [31:0] mm     [NI][256];
    int          clr_left [NI];
    bit          sv     [NI][NCYC];
    logic [31:0] sd     [NI][NCYC];
    logic [31:0] exp_rd [NI];
    int          cyc;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] b, input int nlanes);
        logic [31:0] bm;
        bm = '0;
        for (int i = 0; i < nlanes; i++) begin
            if (b[i]) bm = bm | (32'h0000_00FF << (8 * i));
        end
        return (old_w & ~bm) | (new_w & bm);
    endfunction

    task automatic set_in(input logic e, input logic w, input logic [3:0] b,
                          input logic [7:0] a, input logic [31:0] d);
        en = e; we = w; be = b; addr = a; wdata = d;
    endtask

    task automatic rnd_in();
        en    = ($urandom_range(0, 9) < 7);
        we    = $urandom_range(0, 1) != 0;
        be    = 4'($urandom_range(0, 15));
        wdata = $urandom;
        addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
    endtask

    // Evaluate the access presented before the next edge, then check outputs after it.
    task automatic tick();
        for (int k = 0; k < NI; k++) begin
            logic        inr, ret;
            logic [31:0] old_w, new_w, d;
            chk($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(clr_left[k] > 0));
            ret = 1'b0;
            d   = '0;
            if (clr_left[k] > 0) begin
                mm[k][depth_m[k] - clr_left[k]] = '0;
                clr_left[k]--;
            end else if (en) begin
                inr   = (int'(addr) < depth_m[k]);
                old_w = inr ? mm[k][addr] : 32'd0;
                if (we) begin
                    new_w = lane_merge(old_w, wdata & mask_m[k], be, lanes_m[k]);
                    if (inr) mm[k][addr] = new_w;
                    ret = rdm_m[k];
                    d   = inr ? new_w : 32'd0;
                end else begin
                    ret = 1'b1;
                    d   = old_w;
                end
            end
            if (ret) begin
                sv[k][cyc + lat_m[k]] = 1'b1;
                sd[k][cyc + lat_m[k]] = d;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            if (sv[k][cyc]) exp_rd[k] = sd[k][cyc];
            chk($sformatf("rvalid[%0d]", k), 32'(rv[k]), 32'(sv[k][cyc]));
            if (clr_m[k]) chk($sformatf("rdata[%0d]", k), rd[k], exp_rd[k]);
        end
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            for (int j = 1; j <= 3; j++) sv[k][cyc + j] = 1'b0;
            exp_rd[k]   = '0;
            clr_left[k] = clr_m[k] ? depth_m[k] : 0;
            chk($sformatf("rst_rdata[%0d]", k), rd[k], 32'd0);
            chk($sformatf("rst_rvalid[%0d]", k), 32'(rv[k]), 32'd0);
            chk($sformatf("rst_busy[%0d]", k), 32'(bz[k]), 32'(clr_m[k]));
        end
        repeat (hold) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("rsth_busy[%0d]", k), 32'(bz[k]), 32'(clr_m[k]));
                chk($sformatf("rsth_rvalid[%0d]", k), 32'(rv[k]), 32'd0);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic run_clear(input string tag);
        int n;
        n = 0;
        while (bz[0] && n < 400) begin
            rnd_in();
            en = 1'b1;
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd256);
    endtask

    initial begin
        logic [31:0] prev;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        set_in(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        @(negedge clk);
        do_reset(2);
        run_clear("busy_len");

        set_in(1'b1, 1'b0, 4'h0, 8'd128, 32'h0); tick();
        chk("clr_rd128", rd[0], 32'd0);
        chk("clr_rv128", 32'(rv[0]), 32'd1);

        prev = rd[0];
        set_in(1'b1, 1'b1, 4'hF, 8'd5, 32'hAABB_CCDD); tick();
        set_in(1'b1, 1'b1, 4'h5, 8'd5, 32'h1122_3344); tick();
        chk("wt_merge", rd[1], 32'hAA22_CC44);
        chk("wt_vld", 32'(rv[1]), 32'd1);
        chk("nc_vld", 32'(rv[0]), 32'd0);
        chk("nc_hold", rd[0], prev);
        set_in(1'b1, 1'b0, 4'h0, 8'd5, 32'h0); tick();
        chk("lane_rd", rd[0], 32'hAA22_CC44);
        chk("lane_rd8", rd[3], 32'h0000_0044);

        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 1'b1, 4'hF, 8'(i), 32'(i * 16));
            tick();
        end
        set_in(1'b1, 1'b0, 4'h0, 8'd1, 32'h0); tick();
        chk("or_lat1", 32'(rv[2]), 32'd0);
        set_in(1'b1, 1'b0, 4'h0, 8'd2, 32'h0); tick();
        chk("or_first_vld", 32'(rv[2]), 32'd1);
        chk("or_first_dat", rd[2], 32'h10);
        set_in(1'b1, 1'b0, 4'h0, 8'd3, 32'h0); tick();
        set_in(1'b1, 1'b0, 4'h0, 8'd4, 32'h0); tick();
        set_in(1'b0, 1'b0, 4'h0, 8'd0, 32'h0); tick();
        chk("or_last_dat", rd[2], 32'h40);

        set_in(1'b1, 1'b1, 4'hF, 8'd210, 32'h5A); tick();
        set_in(1'b1, 1'b0, 4'h0, 8'd210, 32'h0); tick();
        set_in(1'b0, 1'b0, 4'h0, 8'd0, 32'h0); tick();
        chk("oor_rd", rd[2], 32'd0);
        chk("oor_vld", 32'(rv[2]), 32'd1);

        repeat (1500) begin
            rnd_in();
            tick();
        end

        set_in(1'b1, 1'b1, 4'hF, 8'd200, 32'hDEAD_BEEF); tick();
        set_in(1'b1, 1'b0, 4'h0, 8'd200, 32'h0); tick();
        chk("pre_rst_200", rd[0], 32'hDEAD_BEEF);
        do_reset(2);
        repeat (100) begin
            rnd_in();
            tick();
        end
        do_reset(2);
        run_clear("busy_len2");
        set_in(1'b1, 1'b0, 4'h0, 8'd200, 32'h0); tick();
        chk("clr_200", rd[0], 32'd0);

        repeat (500) begin
            rnd_in();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_ram_be.md
Name: sp_ram_be

Overview:
Parametrised single-port synchronous RAM. It is the next generation of the team's 8x256 single-port RAM. It adds:
- configurable width and depth,
- per-byte write enables,
- a selectable read-during-write mode,
- an optional output pipeline register,
- a read-valid strobe,
- a post-reset memory-clear sequencer.

It sits as a local buffer or scratchpad behind any single-master datapath.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must be ≤ 2**ADDR_W
RD_MODE, 0, 0 = no-change (write leaves rdata unchanged), 1 = write-through (write returns the merged new word)
OUT_REG, 0, 0 = read latency 1, 1 = read latency 2 (extra output register)
CLEAR_ON_RST, 1, 1 = zero every word after reset release, 0 = skip the clear

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  access enable; ignored while busy=1
we  in  1  1 = write, 0 = read; qualified by en
be  in  DATA_W/8  byte-lane write enables; bit i covers wdata[8i+7:8i]
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data
rvalid  out  1  one-cycle strobe: rdata updated this cycle
busy  out  1  clear sequence in progress; accesses are dropped

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rdata=0, rvalid=0, pipeline valid bits=0, clear counter=0.
  - busy=CLEAR_ON_RST.
  - FSM → CLEAR if CLEAR_ON_RST, else READY.
  - The memory array itself is not reset.
- FSM states CLEAR and READY:
  - CLEAR: each cycle writes all-zero to word clr_cnt, all lanes, then increments clr_cnt. Lasts exactly DEPTH cycles. Leaves to READY on the cycle clr_cnt=DEPTH-1 is written. busy=1 throughout, and falls to 0 on the edge entering READY.
  - READY: normal access; stays here until reset.
- Reset asserted mid-clear: abort. On release, restart the clear from address 0.
- Accepted access condition: en=1 and busy=0.
- Write (we=1):
  - For each lane with be[i]=1, mem[addr] lane i ← wdata lane i. Lanes with be[i]=0 keep their old value.
  - be=0 is a legal no-op write.
  - RD_MODE=0: rdata holds its value and no rvalid is generated.
  - RD_MODE=1: rdata ← merged word (new bytes on enabled lanes, old bytes on others) with rvalid, same latency as a read.
- Read (we=0): rdata ← mem[addr]. be is ignored.
- Latency, measured from the edge that accepts the access:
  - OUT_REG=0: rdata/rvalid update on that same edge; visible the following cycle.
  - OUT_REG=1: one further edge.
  - Back-to-back reads every cycle give rvalid high every cycle (full throughput).
- rvalid is high for exactly one cycle per returned word. With no access, rdata holds its last value.
- Out-of-range address (addr ≥ DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Writes are dropped; memory is unchanged.
  - Reads return 0 with rvalid=1.
- Access attempted while busy=1: fully dropped. No memory change and no rvalid, including in-flight semantics. The master must sample busy.
- Read-modify order within one cycle: the old word is read, then the merge is written. The merged value is computed combinationally from the old word, so there is no hazard with a following read.
- Pipeline registers under OUT_REG=1 are flushed by reset only. A read accepted in the last cycle before reset is lost.

Decomposition:
- Shared package sp_ram_pkg holds:
  - state enum {ST_CLEAR, ST_READY},
  - localparam BE_W = DATA_W/8,
  - RD_MODE encodings RDM_NO_CHANGE=0 and RDM_WRITE_THRU=1,
  - a function that merges old/new words under be.
- One natural sub-module, sp_ram_be_outpipe: the optional output register stage (rdata/rvalid). It is instantiated only when OUT_REG=1 and bypassed otherwise.
- Add elaboration-time checks for: DATA_W%8==0, DEPTH ≤ 2**ADDR_W, DEPTH ≥ 1.

Test Plan:
1. Clear sequence (defaults): release rst_n, hold en=1 → busy=1 for exactly 256 cycles, then 0. Reads of addr 0, 128 and 255 return 0x00 with rvalid one cycle after acceptance.
2. Byte lanes (DATA_W=32, CLEAR_ON_RST=1):
   - Write 0xAABBCCDD, be=4'b1111, to addr 5.
   - Write 0x11223344, be=4'b0101, to addr 5.
   - Read addr 5 → 0xAA22CC44.
3. RD_MODE: do the same two writes as scenario 2.
   - With RD_MODE=1: the second write gives rvalid=1 and rdata=0xAA22CC44 next cycle.
   - With RD_MODE=0: rvalid stays 0 and rdata keeps its prior value.
4. OUT_REG=1 back-to-back reads: write addr 1..4 = 0x10..0x40, then read 1,2,3,4 on consecutive cycles → rvalid high 4 consecutive cycles, starting 2 cycles after the first read, with data 0x10,0x20,0x30,0x40.
5. Reset mid-clear: assert rst_n=0 at clear cycle 100, release → busy lasts a full 256 cycles again. Words previously written at addr 200 read 0x00.
6. Out-of-range/busy drop (DEPTH=200, ADDR_W=8):
   - Write 0x5A to addr 210, then read addr 210 → rdata 0x00, rvalid=1.
   - A write issued while busy=1 is absent after the clear.
